// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle: decode/execute status in, stall/flush/forward controls and
// performance counters out. master = pipeline side, slave = hazard controller.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_regwrite;
  logic                  id_memread;
  logic                  ex_busy;
  logic                  redirect;
  logic                  stall_f;
  logic                  stall_d;
  logic                  stall_e;
  logic                  flush_d;
  logic                  flush_e;
  logic                  flush_m;
  logic [1:0]            fwd_a_e;
  logic [1:0]            fwd_b_e;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_regwrite, id_memread, ex_busy, redirect,
    input  stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
           fwd_a_e, fwd_b_e, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_regwrite, id_memread, ex_busy, redirect,
    output stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
           fwd_a_e, fwd_b_e, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use/busy stalls, redirect flushes, EX forwarding.
// Optional stall/redirect performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int BR_RESOLVE = 2,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  rs1_used;
    logic                  rs2_used;
  } entry_t;

  localparam entry_t BUBBLE = '0;
  localparam logic   BR_MEM = (BR_RESOLVE == 2);

  entry_t d_entry;
  entry_t e_q, e_d, m_q, m_d, w_q, w_d;
  logic   lu;
  logic   stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;

  // Invalid decode slots enter EX as bubbles so they can never hazard or forward.
  always_comb begin
    d_entry          = BUBBLE;
    d_entry.valid    = hz.id_valid;
    d_entry.rd       = hz.id_rd;
    d_entry.regwrite = hz.id_valid & hz.id_regwrite;
    d_entry.memread  = hz.id_valid & hz.id_memread;
    d_entry.rs1      = hz.id_rs1;
    d_entry.rs2      = hz.id_rs2;
    d_entry.rs1_used = hz.id_valid & hz.id_rs1_used;
    d_entry.rs2_used = hz.id_valid & hz.id_rs2_used;
  end

  assign lu = e_q.valid && e_q.memread && (e_q.rd != '0) &&
              ((d_entry.rs1_used && (d_entry.rs1 == e_q.rd)) ||
               (d_entry.rs2_used && (d_entry.rs2 == e_q.rd)));

  // Redirect outranks busy, which outranks load-use.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    e_d     = d_entry;
    m_d     = e_q;
    w_d     = m_q;
    if (hz.redirect) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      e_d     = BUBBLE;
      if (BR_MEM) begin
        flush_m = 1'b1;
        m_d     = BUBBLE;
      end
    end else if (hz.ex_busy) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
      e_d     = e_q;
      m_d     = BUBBLE;
    end else if (lu) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
      e_d     = BUBBLE;
    end
    // Controls drop the moment reset asserts, without waiting for a clock.
    if (!reset) begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_m = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q <= BUBBLE;
      m_q <= BUBBLE;
      w_q <= BUBBLE;
    end else begin
      // NOTE: non-blocking so E, M and W all shift from their pre-edge values.
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs, input logic used,
                                         input entry_t m, input entry_t w);
    if (used && (rs != '0) && m.valid && m.regwrite && (m.rd == rs))      return 2'b10;
    else if (used && (rs != '0) && w.valid && w.regwrite && (w.rd == rs)) return 2'b01;
    else                                                                  return 2'b00;
  endfunction

  assign hz.fwd_a_e = fwd_sel(e_q.rs1, e_q.rs1_used, m_q, w_q);
  assign hz.fwd_b_e = fwd_sel(e_q.rs2, e_q.rs2_used, m_q, w_q);
  assign hz.stall_f = stall_f;
  assign hz.stall_d = stall_d;
  assign hz.stall_e = stall_e;
  assign hz.flush_d = flush_d;
  assign hz.flush_e = flush_e;
  assign hz.flush_m = flush_m;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // Saturating counters: they stick at all-ones rather than wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_f && (stall_cnt_q != '1))     stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (hz.redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
`endif

endmodule
